alu_issue_sequencer: RTL

//  Shares the single 32-bit combinational ALU between two requesters (req 0, req 1).

---
 rtl/alu_issue_sequencer_pkg.sv | 46 ++++
 rtl/alu_issue_sequencer_rr_arbiter2.sv | 19 +
 rtl/alu_issue_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_issue_sequencer_pkg.sv
// Shared opcode constants, FSM encoding and decode helpers for the ALU issue sequencer.
package alu_issue_sequencer_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned ALUOP_W = 2;
   localparam int unsigned DATA_W  = 32;

   localparam logic [OP_W-1:0] OP_ADD = 6'b000000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b000001;
   localparam logic [OP_W-1:0] OP_AND = 6'b000010;
   localparam logic [OP_W-1:0] OP_OR  = 6'b000011;
   localparam logic [OP_W-1:0] OP_XOR = 6'b000100;
   localparam logic [OP_W-1:0] OP_SLT = 6'b000101;
   localparam logic [OP_W-1:0] OP_SLL = 6'b000110;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000111;
   localparam logic [OP_W-1:0] OP_SRA = 6'b001000;
   localparam logic [OP_W-1:0] OP_MUL = 6'b001001;
   localparam logic [OP_W-1:0] OP_DIV = 6'b001010;
   localparam logic [OP_W-1:0] OP_MOD = 6'b001011;

   localparam logic [ALUOP_W-1:0] ALUOP_BNE = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_BEQ = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Operation field only decodes when ALUOp is an R-type/immediate class (00 or 10).
   function automatic logic op_field_used(input logic [ALUOP_W-1:0] aluop);
      return (aluop == 2'b00) || (aluop == 2'b10);
   endfunction

   function automatic logic is_muldiv(input logic [OP_W-1:0] op,
                                      input logic [ALUOP_W-1:0] aluop);
      return op_field_used(aluop) &&
             ((op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD));
   endfunction

   function automatic logic is_divmod(input logic [OP_W-1:0] op,
                                      input logic [ALUOP_W-1:0] aluop);
      return op_field_used(aluop) && ((op == OP_DIV) || (op == OP_MOD));
   endfunction

endpackage

// File: rtl/alu_issue_sequencer_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic       grant_c,
   output logic       grant_valid_c
);

   always_comb begin
      grant_valid_c = |req_valid;
      grant_c       = 1'b0;
      case (req_valid)
         2'b10:   grant_c = 1'b1;
         2'b11:   grant_c = ~last_grant;
         default: grant_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Shares one combinational ALU between two requesters; holds operands for a per-op latency.
// Optional divide/modulo-by-zero trap enabled by defining ALU_SEQ_DIV0_TRAP_EN.
module alu_issue_sequencer
   import alu_issue_sequencer_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = 4,
   parameter int unsigned SIMPLE_LAT = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [11:0] req_operation,
   input  logic [3:0]  req_aluop,
   input  logic [63:0] req_data1,
   input  logic [63:0] req_data2,
   output logic [31:0] alu_data1,
   output logic [31:0] alu_data2,
   output logic [5:0]  alu_operation,
   output logic [1:0]  alu_aluop,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_err
);

   localparam int unsigned MAX_LAT = (MULDIV_LAT > SIMPLE_LAT) ? MULDIV_LAT : SIMPLE_LAT;
   localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   state_t              state;
   logic                last_grant;
   logic [CNT_W-1:0]    cnt;
   logic                err_q;

   logic                grant_c;
   logic                grant_valid_c;
   logic                accept_c;
   logic                trap_c;
   logic [OP_W-1:0]     sel_op_c;
   logic [ALUOP_W-1:0]  sel_aluop_c;
   logic [DATA_W-1:0]   sel_data1_c;
   logic [DATA_W-1:0]   sel_data2_c;
   logic [CNT_W-1:0]    lat_m1_c;

   rr_arbiter2 u_arb (
      .req_valid     (req_valid),
      .last_grant    (last_grant),
      .grant_c       (grant_c),
      .grant_valid_c (grant_valid_c)
   );

   assign sel_op_c    = grant_c ? req_operation[11:6] : req_operation[5:0];
   assign sel_aluop_c = grant_c ? req_aluop[3:2]      : req_aluop[1:0];
   assign sel_data1_c = grant_c ? req_data1[63:32]    : req_data1[31:0];
   assign sel_data2_c = grant_c ? req_data2[63:32]    : req_data2[31:0];

   assign lat_m1_c = is_muldiv(sel_op_c, sel_aluop_c) ? CNT_W'(MULDIV_LAT - 1)
                                                       : CNT_W'(SIMPLE_LAT - 1);

`ifdef ALU_SEQ_DIV0_TRAP_EN
   assign trap_c = is_divmod(sel_op_c, sel_aluop_c) && (sel_data2_c == '0);
`else
   assign trap_c = 1'b0;
`endif

   assign accept_c = (state == ST_IDLE) && grant_valid_c;

   // Ready is masked during reset so every output reads 0 while reset_n is low.
   assign req_ready = (accept_c && reset_n) ? (grant_c ? 2'b10 : 2'b01) : 2'b00;

   assign rsp_err = err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         last_grant    <= 1'b1;
         cnt           <= '0;
         alu_data1     <= '0;
         alu_data2     <= '0;
         alu_operation <= '0;
         alu_aluop     <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= 1'b0;
         rsp_result    <= '0;
         rsp_zero      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_valid_c) begin
                  alu_data1     <= sel_data1_c;
                  alu_data2     <= sel_data2_c;
                  alu_operation <= sel_op_c;
                  alu_aluop     <= sel_aluop_c;
                  rsp_id        <= grant_c;
                  last_grant    <= grant_c;
                  if (trap_c) begin
                     rsp_result <= '1;
                     rsp_zero   <= 1'b0;
                     err_q      <= 1'b1;
                     rsp_valid  <= 1'b1;
                     state      <= ST_RESP;
                  end else begin
                     cnt   <= lat_m1_c;
                     state <= ST_EXEC;
                  end
               end
            end
            // Operands stay parked on the ALU until the countdown expires.
            ST_EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  rsp_result <= alu_result;
                  rsp_zero   <= alu_zero;
                  err_q      <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
